// File: rtl/idu_dec_queue_if.sv
// Handshake bundle for one side of the decoded-instruction queue.
// The producer of an instruction drives valid/payload/pc/old_pc/branch_taken
// and the consumer drives ready.
interface idu_dec_queue_if #(
    parameter int PAYLOAD_W = 128,
    parameter int ADDR_W    = 32
);
    logic                 valid;
    logic                 ready;
    logic [PAYLOAD_W-1:0] payload;
    logic [ADDR_W-1:0]    pc;
    logic [ADDR_W-1:0]    old_pc;
    logic                 branch_taken;

    // Producer side (decode feeding the queue, or the queue feeding EX)
    modport master (
        output valid,
        output payload,
        output pc,
        output old_pc,
        output branch_taken,
        input  ready
    );

    // Consumer side
    modport slave (
        input  valid,
        input  payload,
        input  pc,
        input  old_pc,
        input  branch_taken,
        output ready
    );
endinterface

// File: rtl/idu_dec_queue.sv
// Decoded-instruction queue between decode and EX.
// DEPTH-entry circular FIFO (DEPTH >= 2, any value, not only powers of two).
// The handshake outputs come only from registered state: ready is
// count < DEPTH and valid is count != 0. A full queue does not accept a new
// entry in the same cycle that it pops one. While the queue is empty the
// head data outputs are driven to zero so EX sees a NOP bubble. flush_i
// takes priority over push, pop and stall. stall_i blocks only the dequeue
// side.
module idu_dec_queue #(
    parameter int  PAYLOAD_W = 128,
    parameter int  ADDR_W    = 32,
    parameter int  DEPTH     = 4,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  stall_i,
    idu_dec_queue_if.slave        in_if,
    idu_dec_queue_if.master       out_if,
    output logic [CNT_W-1:0]      count_o
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    logic [PAYLOAD_W-1:0] payload_mem [DEPTH];
    logic [ADDR_W-1:0]    pc_mem      [DEPTH];
    logic [ADDR_W-1:0]    old_pc_mem  [DEPTH];
    logic                 bt_mem      [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;

    logic                 not_empty;
    logic                 push;
    logic                 pop;

    // Explicit wrap so that depths that are not powers of two work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign not_empty    = (count_q != '0);
    assign in_if.ready  = (count_q < CNT_FULL);
    assign out_if.valid = not_empty;
    assign push         = in_if.valid & in_if.ready;
    assign pop          = not_empty & out_if.ready & ~stall_i;
    assign count_o      = count_q;

    // Write and read pointers. A flush rewinds both pointers to the start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
        end
    end

    // Occupancy. A push and a pop in the same cycle leave it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage, not reset. A push accepted in a flush cycle is dropped.
    // Writes never target the head slot while it is visible, because a push
    // happens only when the queue is not full.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            payload_mem[wr_ptr_q] <= in_if.payload;
            pc_mem[wr_ptr_q]      <= in_if.pc;
            old_pc_mem[wr_ptr_q]  <= in_if.old_pc;
            bt_mem[wr_ptr_q]      <= in_if.branch_taken;
        end
    end

    // Head data goes to EX directly. An empty queue drives a zero bundle.
    always_comb begin
        out_if.payload      = '0;
        out_if.pc           = '0;
        out_if.old_pc       = '0;
        out_if.branch_taken = 1'b0;
        if (not_empty) begin
            out_if.payload      = payload_mem[rd_ptr_q];
            out_if.pc           = pc_mem[rd_ptr_q];
            out_if.old_pc       = old_pc_mem[rd_ptr_q];
            out_if.branch_taken = bt_mem[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_idu_dec_queue.sv
// Bench for idu_dec_queue. A DEPTH=4 instance and a DEPTH=3 instance get
// identical stimulus. Each instance has its own queue-based reference model.
module tb_idu_dec_queue;

    localparam int PW = 128;
    localparam int AW = 32;

    typedef struct packed {
        logic [PW-1:0] payload;
        logic [AW-1:0] pc;
        logic [AW-1:0] old_pc;
        logic          bt;
    } ent_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          flush     = 1'b0;
    logic          stall     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic          bt        = 1'b0;
    logic [PW-1:0] payload   = '0;
    logic [AW-1:0] pc        = '0;
    logic [AW-1:0] old_pc    = '0;
    logic [2:0]    cnt4;
    logic [1:0]    cnt3;

    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t mq [2][$];

    always #5 clk = ~clk;

    idu_dec_queue_if #(.PAYLOAD_W(PW), .ADDR_W(AW)) i4 ();
    idu_dec_queue_if #(.PAYLOAD_W(PW), .ADDR_W(AW)) o4 ();
    idu_dec_queue_if #(.PAYLOAD_W(PW), .ADDR_W(AW)) i3 ();
    idu_dec_queue_if #(.PAYLOAD_W(PW), .ADDR_W(AW)) o3 ();

    assign i4.valid        = in_valid;
    assign i4.payload      = payload;
    assign i4.pc           = pc;
    assign i4.old_pc       = old_pc;
    assign i4.branch_taken = bt;
    assign o4.ready        = out_ready;
    assign i3.valid        = in_valid;
    assign i3.payload      = payload;
    assign i3.pc           = pc;
    assign i3.old_pc       = old_pc;
    assign i3.branch_taken = bt;
    assign o3.ready        = out_ready;

    idu_dec_queue #(.PAYLOAD_W(PW), .ADDR_W(AW), .DEPTH(4)) u_q4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .stall_i (stall),
        .in_if   (i4),
        .out_if  (o4),
        .count_o (cnt4)
    );

    idu_dec_queue #(.PAYLOAD_W(PW), .ADDR_W(AW), .DEPTH(3)) u_q3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .stall_i (stall),
        .in_if   (i3),
        .out_if  (o3),
        .count_o (cnt3)
    );

    task automatic cmp(input string name, input int depth,
                       input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s depth%0d @%0t: got %0h, expected %0h",
                     name, depth, $time, act, exp);
        end
    endtask

    // Compare one instance against its model, then advance the model by the
    // handshake that will take effect at the next rising edge.
    task automatic observe(input int k, input int depth,
                           input logic ov, input logic ir,
                           input logic [PW-1:0] op, input logic [AW-1:0] opc,
                           input logic [AW-1:0] oold, input logic obt,
                           input int cnt);
        ent_t e;
        ent_t n;
        int   sz;
        if (!rst_n) mq[k].delete();
        sz = mq[k].size();
        e  = (sz != 0) ? mq[k][0] : '0;
        cmp("out_valid",    depth, PW'(ov),   PW'(sz != 0));
        cmp("in_ready",     depth, PW'(ir),   PW'(sz < depth));
        cmp("count",        depth, PW'(cnt),  PW'(sz));
        cmp("out_payload",  depth, op,        e.payload);
        cmp("out_pc",       depth, PW'(opc),  PW'(e.pc));
        cmp("out_old_pc",   depth, PW'(oold), PW'(e.old_pc));
        cmp("out_bt",       depth, PW'(obt),  PW'(e.bt));
        if (rst_n) begin
            if (flush) begin
                mq[k].delete();
            end else begin
                if (sz != 0 && out_ready && !stall) void'(mq[k].pop_front());
                if (in_valid && sz < depth) begin
                    n = {payload, pc, old_pc, bt};
                    mq[k].push_back(n);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        observe(0, 4, o4.valid, i4.ready, o4.payload, o4.pc, o4.old_pc,
                o4.branch_taken, int'(cnt4));
        observe(1, 3, o3.valid, i3.ready, o3.payload, o3.pc, o3.old_pc,
                o3.branch_taken, int'(cnt3));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_entry();
        payload = {$urandom, $urandom, $urandom, $urandom};
        pc      = $urandom;
        old_pc  = $urandom;
        bt      = 1'($urandom_range(0, 1));
    endtask

    logic accepted;

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Single push with a known PC and payload
        in_valid = 1'b1;
        pc       = 32'h8000_0000;
        old_pc   = 32'h7fff_fffc;
        payload  = {16{8'hA5}};
        bt       = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        out_ready = 1'b1;
        repeat (2) tick();

        // Fill until full while EX is blocked; the data is held until it is accepted
        out_ready = 1'b0;
        in_valid  = 1'b1;
        new_entry();
        repeat (6) begin
            accepted = i4.ready;
            tick();
            if (accepted) new_entry();
        end
        // Pop once while full; ready must stay low during that cycle
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (2) tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();

        // Flush with a push in the same cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        new_entry(); tick();
        new_entry(); tick();
        new_entry(); flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) tick();

        // Stall holds the head while pushes continue
        stall     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        new_entry(); tick();
        new_entry(); tick();
        in_valid = 1'b0;
        repeat (3) tick();
        stall = 1'b0;
        repeat (4) tick();

        // Back-to-back push and pop at occupancy 1 to exercise pointer wrap
        out_ready = 1'b0;
        in_valid  = 1'b1;
        new_entry(); tick();
        out_ready = 1'b1;
        repeat (12) begin
            new_entry();
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();

        // Random traffic with occasional stall, flush and mid-run reset
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            stall     = ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 40) == 0);
            new_entry();
            if ($urandom_range(0, 250) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        stall    = 1'b0;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
